// File: rtl/datamem_arb_pkg.sv
// rtl/datamem_arb_pkg.sv - shared types and constants for the data memory arbiter
package datamem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/datamem_arbiter_if.sv
// rtl/datamem_arbiter_if.sv - request, response and memory bus of the data memory arbiter
interface datamem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  req0_valid;
  logic                  req1_valid;
  logic                  req0_ready;
  logic                  req1_ready;
  logic                  req0_we;
  logic                  req1_we;
  logic [DATA_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  resp0_valid;
  logic                  resp1_valid;
  logic                  resp0_err;
  logic                  resp1_err;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic [DATA_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rd;

  modport slave (
    input  req0_valid, req1_valid, req0_we, req1_we,
    input  req0_addr, req1_addr, req0_wdata, req1_wdata, mem_rd,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
    output resp0_err, resp1_err, resp_rdata, mem_a, mem_wd, mem_we
  );

  modport master (
    output req0_valid, req1_valid, req0_we, req1_we,
    output req0_addr, req1_addr, req0_wdata, req1_wdata, mem_rd,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
    input  resp0_err, resp1_err, resp_rdata, mem_a, mem_wd, mem_we
  );

endinterface

// File: rtl/datamem_arbiter_rr.sv
// rtl/datamem_arbiter_rr.sv - two-way round-robin grant; last_grant moves only on advance
module rr_arbiter2
  import datamem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q;

  // On a tie the port that did not win last time gets the grant
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == PORT_DMA) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= PORT_DMA;
    end else if (advance) begin
      last_q <= gnt[PORT_DMA];
    end
  end

endmodule

// File: rtl/datamem_arbiter.sv
// rtl/datamem_arbiter.sv - two-port arbiter/sequencer in front of the single-port data memory
module datamem_arbiter
  import datamem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 32
) (
  input logic               clk,
  input logic               rst,
  datamem_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_RESP   = RESP;

  logic [1:0]            state_q, state_d;
  logic                  port_q, we_q, err_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;

  logic [1:0]            arb_req, gnt;
  logic                  hs, sel;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_addr, sel_wdata;

  // Requests are only offered to the arbiter while idle and out of reset
  assign arb_req = (state_q == S_IDLE && !rst) ? {bus.req1_valid, bus.req0_valid} : 2'b00;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (hs),
    .gnt     (gnt)
  );

  assign hs        = |gnt;
  assign sel       = gnt[PORT_DMA];
  assign sel_we    = sel ? bus.req1_we    : bus.req0_we;
  assign sel_addr  = sel ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = sel ? bus.req1_wdata : bus.req0_wdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (hs) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        port_q  <= sel;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        err_q   <= (sel_addr >= DATA_WIDTH'(MEM_DEPTH));
      end
      if (state_q == S_ACCESS) begin
        rdata_q <= (!we_q && !err_q) ? bus.mem_rd : '0;
      end
    end
  end

  assign bus.req0_ready  = gnt[PORT_CPU];
  assign bus.req1_ready  = gnt[PORT_DMA];
  assign bus.mem_a       = addr_q;
  assign bus.mem_wd      = wdata_q;
  assign bus.mem_we      = (state_q == S_ACCESS) && we_q && !err_q;
  assign bus.resp0_valid = (state_q == S_RESP) && (port_q == PORT_CPU);
  assign bus.resp1_valid = (state_q == S_RESP) && (port_q == PORT_DMA);
  assign bus.resp0_err   = bus.resp0_valid && err_q;
  assign bus.resp1_err   = bus.resp1_valid && err_q;
  assign bus.resp_rdata  = rdata_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// tb/tb_datamem_arbiter.sv - directed self-checking bench for datamem_arbiter
module tb_datamem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] mem [0:31];
  logic        pre_we;
  logic [4:0]  pre_a;
  logic [31:0] pre_d;

  datamem_arbiter_if #(.DATA_WIDTH(32)) bus ();

  datamem_arbiter #(.DATA_WIDTH(32), .MEM_DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rd = mem[bus.mem_a[4:0]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (bus.mem_we) mem[bus.mem_a[4:0]] <= bus.mem_wd;
  end

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic test_reset;
    bus.req0_valid = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b exp 0", bus.req0_ready); end
    checks++;
    if ({bus.mem_we, bus.resp0_valid, bus.resp1_valid, bus.resp0_err, bus.resp1_err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b exp 00000",
        {bus.mem_we, bus.resp0_valid, bus.resp1_valid, bus.resp0_err, bus.resp1_err});
    end
    checks++;
    if (bus.mem_a !== 32'h0 || bus.mem_wd !== 32'h0 || bus.resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: got a=%h wd=%h rd=%h exp 0", bus.mem_a, bus.mem_wd, bus.resp_rdata);
    end
    bus.req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 32'd5; bus.req0_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++; $display("FAIL wr_ready: got %b%b exp 01", bus.req1_ready, bus.req0_ready);
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_a !== 32'd5 || bus.mem_wd !== 32'hDEADBEEF || bus.req0_ready !== 1'b0) begin
      errors++; $display("FAIL wr_access: got we=%b a=%h wd=%h exp we=1 a=5 wd=deadbeef", bus.mem_we, bus.mem_a, bus.mem_wd);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.resp0_valid !== 1'b1 || bus.resp0_err !== 1'b0 || bus.resp1_valid !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL wr_resp: got v0=%b e0=%b v1=%b we=%b exp 1 0 0 0",
        bus.resp0_valid, bus.resp0_err, bus.resp1_valid, bus.mem_we);
    end
    @(negedge clk);
    checks++;
    if (bus.resp0_valid !== 1'b0) begin errors++; $display("FAIL wr_resp_pulse: got %b exp 0", bus.resp0_valid); end
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b exp 1", bus.req0_ready); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.resp0_valid !== 1'b1 || bus.resp_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_resp: got v=%b rd=%h exp v=1 rd=deadbeef", bus.resp0_valid, bus.resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    logic [31:0] exp_rd;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    preload(5'd1, 32'h11111111);
    preload(5'd2, 32'h22222222);
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 32'd1;
    bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 32'd2;
    for (int i = 0; i < 4; i++) begin
      exp_rd = (i % 2 == 0) ? 32'h11111111 : 32'h22222222;
      #1;
      checks++;
      if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1)) begin
        errors++; $display("FAIL rr_grant%0d: got r1r0=%b%b exp winner %0d", i, bus.req1_ready, bus.req0_ready, i % 2);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        errors++; $display("FAIL rr_busy%0d: got r1r0=%b%b exp 00", i, bus.req1_ready, bus.req0_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.resp0_valid !== (i % 2 == 0) || bus.resp1_valid !== (i % 2 == 1) || bus.resp_rdata !== exp_rd) begin
        errors++; $display("FAIL rr_resp%0d: got v1v0=%b%b rd=%h exp rd=%h", i,
          bus.resp1_valid, bus.resp0_valid, bus.resp_rdata, exp_rd);
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask

  task automatic test_out_of_range;
    logic [31:0] addrs [3];
    logic        wes   [3];
    logic        errs  [3];
    logic [31:0] rds   [3];
    addrs = '{32'd32, 32'd31, 32'h80000005};
    wes   = '{1'b1, 1'b0, 1'b0};
    errs  = '{1'b1, 1'b0, 1'b1};
    rds   = '{32'h0, 32'h31313131, 32'h0};
    preload(5'd31, 32'h31313131);
    for (int i = 0; i < 3; i++) begin
      bus.req1_valid = 1'b1; bus.req1_we = wes[i]; bus.req1_addr = addrs[i]; bus.req1_wdata = 32'h1234;
      #1;
      checks++;
      if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL oor_ready%0d: got %b exp 1", i, bus.req1_ready); end
      @(negedge clk);
      bus.req1_valid = 1'b0;
      #1;
      checks++;
      if (bus.mem_we !== 1'b0 || bus.mem_a !== addrs[i]) begin
        errors++; $display("FAIL oor_access%0d: got we=%b a=%h exp we=0 a=%h", i, bus.mem_we, bus.mem_a, addrs[i]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.resp1_valid !== 1'b1 || bus.resp1_err !== errs[i] || bus.resp0_valid !== 1'b0 || bus.resp_rdata !== rds[i]) begin
        errors++; $display("FAIL oor_resp%0d: got v=%b e=%b rd=%h exp v=1 e=%b rd=%h", i,
          bus.resp1_valid, bus.resp1_err, bus.resp_rdata, errs[i], rds[i]);
      end
      @(negedge clk);
      checks++;
      if (bus.resp1_err !== 1'b0) begin errors++; $display("FAIL oor_err_idle%0d: got %b exp 0", i, bus.resp1_err); end
    end
    checks++;
    if (mem[0] !== 32'h0) begin errors++; $display("FAIL oor_nowrite: got mem0=%h exp 0", mem[0]); end
  endtask

  task automatic test_reset_midflight;
    preload(5'd7, 32'hAAAA0007);
    bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 32'd7; bus.req0_wdata = 32'h5555;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL mid_access: got we=%b exp 1", bus.mem_we); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_a !== 32'h0) begin
      errors++; $display("FAIL mid_rst_async: got we=%b a=%h exp we=0 a=0", bus.mem_we, bus.mem_a);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (bus.resp0_valid !== 1'b0) begin errors++; $display("FAIL mid_noresp%0d: got %b exp 0", i, bus.resp0_valid); end
      @(negedge clk);
    end
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL mid_idle: got ready0=%b exp 1", bus.req0_ready); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.resp0_valid !== 1'b1 || bus.resp_rdata !== 32'hAAAA0007) begin
      errors++; $display("FAIL mid_old_data: got v=%b rd=%h exp v=1 rd=aaaa0007", bus.resp0_valid, bus.resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_late_port0;
    bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 32'd31;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL late_ready1: got %b exp 1", bus.req1_ready); end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 32'd5;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL late_wait_access: got %b exp 0", bus.req0_ready); end
    @(negedge clk);
    #1;
    checks++;
    if (bus.resp1_valid !== 1'b1 || bus.req0_ready !== 1'b0) begin
      errors++; $display("FAIL late_wait_resp: got v1=%b r0=%b exp 1 0", bus.resp1_valid, bus.req0_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL late_grant: got %b exp 1", bus.req0_ready); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.resp0_valid !== 1'b1 || bus.resp_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL late_resp: got v=%b rd=%h exp v=1 rd=deadbeef", bus.resp0_valid, bus.resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_drop_before_grant;
    bus.req1_valid = 1'b1; bus.req1_we = 1'b1; bus.req1_addr = 32'd3; bus.req1_wdata = 32'h33;
    @(negedge clk);
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 32'd4;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL drop_wait: got %b exp 0", bus.req0_ready); end
    @(negedge clk);
    #1;
    checks++;
    if (bus.resp1_valid !== 1'b1 || bus.req0_ready !== 1'b0) begin
      errors++; $display("FAIL drop_resp1: got v1=%b r0=%b exp 1 0", bus.resp1_valid, bus.req0_ready);
    end
    bus.req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.resp0_valid !== 1'b0 || bus.req0_ready !== 1'b0) begin
        errors++; $display("FAIL drop_none%0d: got v0=%b r0=%b exp 0 0", i, bus.resp0_valid, bus.req0_ready);
      end
    end
    checks++;
    if (mem[3] !== 32'h33) begin errors++; $display("FAIL drop_wr_commit: got %h exp 33", mem[3]); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    repeat (2) @(negedge clk);
    test_reset;
    test_write_read;
    test_round_robin;
    test_out_of_range;
    test_reset_midflight;
    test_late_port0;
    test_drop_before_grant;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
